// File: rtl/nasser_hadi_dlatch.sv
// TinyTapeout D-latch tile: 8-bit gated latch emulated on clk,
// with Q/Qbar output select, synchronous clear and status bits.
module nasser_hadi_dlatch (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic       gate;
   logic       qn_sel;
   logic       clr;
   logic [7:0] q;
   logic       gate_open;
   logic [2:0] chg_cnt;
   logic       unused_pins;

   assign gate        = uio_in[0];
   assign qn_sel      = uio_in[1];
   assign clr         = uio_in[2];
   assign unused_pins = &{1'b0, uio_in[7:3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q         <= 8'h00;
         gate_open <= 1'b0;
         chg_cnt   <= 3'd0;
      end else if (ena) begin
         if (clr) begin
            q         <= 8'h00;
            chg_cnt   <= 3'd0;
            gate_open <= gate;
         end else if (gate) begin
            q         <= ui_in;
            gate_open <= 1'b1;
            // only loads that actually change Q are counted
            if (ui_in != q) begin
               chg_cnt <= chg_cnt + 3'd1;
            end
         end else begin
            gate_open <= 1'b0;
         end
      end
   end

   assign uo_out  = qn_sel ? ~q : q;
   assign uio_out = {chg_cnt, gate_open, 4'b0000};
   assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_nasser_hadi_dlatch.sv
// Self-checking bench for nasser_hadi_dlatch: directed steps
// followed by random stimulus against a behavioural model.
module tb_nasser_hadi_dlatch;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int total;
   int bad;

   int m_q;
   int m_gate;
   int m_cnt;

   nasser_hadi_dlatch dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_uo();
      int v;
      v = uio_in[1] ? (255 - m_q) : m_q;
      return 8'(v);
   endfunction

   function automatic logic [7:0] exp_uio();
      return 8'(m_cnt * 32 + m_gate * 16);
   endfunction

   task automatic check_all(input string tag);
      chk({tag, "_uo"}, uo_out, exp_uo());
      chk({tag, "_uio"}, uio_out, exp_uio());
      chk({tag, "_oe"}, uio_oe, 8'hF0);
   endtask

   task automatic model_reset();
      m_q    = 0;
      m_gate = 0;
      m_cnt  = 0;
   endtask

   // one rising edge: update model from current inputs, then sample
   task automatic tick(input string tag);
      int d;
      d = int'(ui_in);
      if (ena) begin
         if (uio_in[2]) begin
            m_q    = 0;
            m_cnt  = 0;
            m_gate = int'(uio_in[0]);
         end else if (uio_in[0]) begin
            if (d != m_q) m_cnt = (m_cnt + 1) % 8;
            m_q    = d;
            m_gate = 1;
         end else begin
            m_gate = 0;
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   function automatic logic [7:0] pins(input bit g, input bit qn,
                                       input bit c);
      return {5'b10101, c, qn, g};
   endfunction

   logic [7:0] vals [9];

   initial begin
      total  = 0;
      bad    = 0;
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      model_reset();
      vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
               8'h06, 8'h07, 8'h08, 8'h09};

      // reset state
      #12;
      check_all("rst");
      chk("rst_uo0", uo_out, 8'h00);
      chk("rst_uio0", uio_out, 8'h00);
      uio_in = pins(0, 1, 0);
      #1;
      chk("rst_qn", uo_out, 8'hFF);
      uio_in = pins(0, 0, 0);
      rst_n  = 1'b1;
      @(posedge clk);
      #1;

      // load and hold
      ena    = 1'b1;
      ui_in  = 8'hA5;
      uio_in = pins(1, 0, 0);
      tick("load");
      chk("load_uo", uo_out, 8'hA5);
      chk("load_uio", uio_out, 8'h30);
      ui_in  = 8'h3C;
      uio_in = pins(0, 0, 0);
      for (int i = 0; i < 3; i++) tick("hold");
      chk("hold_uo", uo_out, 8'hA5);
      chk("hold_uio", uio_out, 8'h20);

      // identical reloads do not count, distinct ones wrap
      ui_in  = 8'hA5;
      uio_in = pins(1, 0, 0);
      for (int i = 0; i < 4; i++) tick("same");
      chk("same_uio", uio_out, 8'h30);
      for (int i = 0; i < 9; i++) begin
         ui_in = vals[i];
         tick("wrap");
      end
      chk("wrap_uio", uio_out, 8'h50);
      chk("wrap_uo", uo_out, 8'h09);

      // clear dominates gate, then ena=0 freezes state
      ui_in = 8'hA5;
      tick("pre_clr");
      ui_in  = 8'hFF;
      uio_in = pins(1, 0, 1);
      tick("clr");
      chk("clr_uo", uo_out, 8'h00);
      chk("clr_uio", uio_out, 8'h10);
      uio_in = pins(0, 0, 1);
      tick("clr0");
      chk("clr0_uio", uio_out, 8'h00);
      ui_in  = 8'hA5;
      uio_in = pins(1, 0, 0);
      tick("reload");
      ena    = 1'b0;
      ui_in  = 8'h77;
      uio_in = pins(1, 0, 1);
      tick("ena0");
      chk("ena0_uo", uo_out, 8'hA5);
      chk("ena0_uio", uio_out, 8'h30);

      // output select is combinational and leaves Q alone
      ena    = 1'b1;
      uio_in = pins(0, 1, 0);
      #1;
      chk("qn_on", uo_out, 8'h5A);
      uio_in = pins(0, 0, 0);
      #1;
      chk("qn_off", uo_out, 8'hA5);

      // async reset mid-stream
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_uo", uo_out, 8'h00);
      check_all("arst");
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      ui_in  = 8'h42;
      uio_in = pins(1, 0, 0);
      tick("post_rst");
      chk("post_rst_uo", uo_out, 8'h42);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         ena    = ($urandom_range(0, 7) != 0);
         uio_in = 8'($urandom);
         if ($urandom_range(0, 3) == 0) uio_in[2] = 1'b1;
         else uio_in[2] = 1'b0;
         if ($urandom_range(0, 2) == 0) ui_in = 8'(m_q);
         else ui_in = 8'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all("rnd_rst");
            #1;
            rst_n = 1'b1;
         end
         tick("rnd");
         uio_in[1] = ~uio_in[1];
         #1;
         chk("rnd_qn", uo_out, exp_uo());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
